// File: rtl/sw_vector_sweeper_pkg.sv
// sw_vector_sweeper_pkg: state encoding and settle-counter sizing shared by the sweeper.
package sw_vector_sweeper_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_SAMPLE = 2'd2, S_DONE = 2'd3} state_t;
   localparam int SETTLE_DEF = 4;
   function automatic int cnt_w(input int s);
      return $clog2(s + 1);
   endfunction
   localparam int CNT_W_DEF = cnt_w(SETTLE_DEF);
endpackage

// File: rtl/sw_vector_sweeper_settle_timer.sv
// sweep_settle_timer: clearable up-counter flagging the last settle cycle.
module sweep_settle_timer #(
   parameter int SETTLE = 4,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);
   always_ff @(posedge clk)
      if (!rst_n || load) cnt <= '0;
      else if (en) cnt <= cnt + CW'(1);
   assign tc = cnt == CW'(SETTLE - 1);
endmodule

// File: rtl/sw_vector_sweeper.sv
// sw_vector_sweeper: walks stim through every combination, samples resp against exp after a settle delay.
module sw_vector_sweeper
   import sw_vector_sweeper_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int RESP_W = 2,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [WIDTH-1:0]  stim,
   input  logic [RESP_W-1:0] resp,
   input  logic [RESP_W-1:0] exp,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [WIDTH:0]    err_count,
   output logic [WIDTH-1:0]  first_fail,
   output logic              first_fail_valid
);
   localparam int CW = cnt_w(SETTLE);
   state_t state;
   logic [CW-1:0] cnt;
   logic tc, go, miss;
   assign go = (state == S_IDLE || state == S_DONE) && start;
   assign miss = resp != exp;
   sweep_settle_timer #(.SETTLE(SETTLE), .CW(CW)) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .load(go || state == S_SAMPLE),
      .en(state == S_SETTLE),
      .cnt(cnt),
      .tc(tc)
   );
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= S_IDLE;
         stim <= '0;
         err_count <= '0;
         first_fail <= '0;
         first_fail_valid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
      end else
         case (state)
            S_IDLE, S_DONE:
               if (go) begin
                  state <= S_SETTLE;
                  stim <= '0;
                  err_count <= '0;
                  first_fail <= '0;
                  first_fail_valid <= 1'b0;
                  busy <= 1'b1;
                  done <= 1'b0;
                  pass <= 1'b0;
               end
            S_SETTLE: state <= tc ? S_SAMPLE : S_SETTLE;
            S_SAMPLE: begin
               if (miss) err_count <= err_count + (WIDTH+1)'(1);
               if (miss && !first_fail_valid) begin
                  first_fail <= stim;
                  first_fail_valid <= 1'b1;
               end
               // pass must account for a mismatch on the final vector itself
               if (&stim) begin
                  state <= S_DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= !miss && err_count == '0;
               end else begin
                  stim <= stim + WIDTH'(1);
                  state <= S_SETTLE;
               end
            end
            default: state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_sw_vector_sweeper.sv
// tb_sw_vector_sweeper: timeline model of a sweep (5 cycles per vector) checked against the DUT every cycle.
module tb_sw_vector_sweeper;
   localparam int N = 128;
   localparam int PER = 5;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [6:0] stim, first_fail;
   logic [1:0] resp, exp, inj;
   logic busy, done, pass, first_fail_valid;
   logic [7:0] err_count;
   int compared = 0, mismatched = 0;
   int mode = 0, sweep_mode = 0;
   int k = 0;
   int phase = 0;
   int cyc;

   sw_vector_sweeper dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp), .exp(exp),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_fail(first_fail), .first_fail_valid(first_fail_valid)
   );

   always #5 clk = ~clk;

   // golden response and injected faults; mode 3 corrupts resp everywhere except the sample cycle
   assign exp = {stim[6] ^ stim[0], &stim[2:0]};
   assign inj = (mode == 1 && stim == 7'h05) ? 2'b01 :
                (mode == 2) ? 2'b11 :
                (mode == 3 && !(phase == 1 && k % PER == PER - 1)) ? 2'b11 : 2'b00;
   assign resp = exp ^ inj;

   function automatic bit faulty(input int m, input int v);
      return (m == 1 && v == 5) || m == 2;
   endfunction
   function automatic int nf(input int m, input int n);
      int c = 0;
      for (int v = 0; v < n; v++) if (faulty(m, v)) c++;
      return c;
   endfunction
   function automatic int ffirst(input int m, input int n);
      for (int v = 0; v < n; v++) if (faulty(m, v)) return v;
      return -1;
   endfunction

   // phase 0: post-reset idle, 1: sweeping (k = cycles since start edge), 2: done
   always @(posedge clk)
      if (!rst_n) phase <= 0;
      else if (start && phase != 1) begin
         phase <= 1;
         k <= 0;
         sweep_mode <= mode;
      end else if (phase == 1) begin
         if (k == N * PER - 1) phase <= 2;
         else k <= k + 1;
      end

   always @(negedge clk) begin
      logic [25:0] act, req;
      int n, f;
      n = phase == 1 ? k / PER : N;
      f = ffirst(sweep_mode, n);
      act = {stim, busy, done, pass, err_count, first_fail, first_fail_valid};
      if (phase == 0) req = '0;
      else req = {7'(phase == 1 ? n : N - 1), phase == 1, phase == 2,
                  phase == 2 && nf(sweep_mode, N) == 0, 8'(nf(sweep_mode, n)),
                  7'(f < 0 ? 0 : f), f >= 0};
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL cycle_check t=%0t phase=%0d k=%0d got {stim,busy,done,pass,err,ff,ffv}=%h want %h",
                  $time, phase, k, act, req);
      end
   end

   task automatic check(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   // pk: k at which to pulse start mid-sweep; rk: k at which to assert reset (-1 = never)
   task automatic sweep(input int m, input int pk, input int rk, output int c);
      mode = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (!done && c < 1000) begin
         @(negedge clk);
         c++;
         start = phase == 1 && k == pk;
         if (phase == 1 && k == rk) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
      end
      start = 1'b0;
      if (!done) begin
         mismatched++;
         $display("FAIL sweep_timeout got done=%b after %0d cycles want 1", done, c);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_err", err_count, 0);
      sweep(0, -1, -1, cyc);
      check("clean_latency", cyc, 640);
      check("clean_pass", pass, 1);
      check("clean_err", err_count, 0);
      check("clean_ffv", first_fail_valid, 0);
      sweep(1, 16 * PER + 1, -1, cyc);
      check("bit0_latency", cyc, 640);
      check("bit0_err", err_count, 1);
      check("bit0_first_fail", first_fail, 'h05);
      check("bit0_ffv", first_fail_valid, 1);
      check("bit0_pass", pass, 0);
      sweep(2, -1, -1, cyc);
      check("inv_err", err_count, 'h80);
      check("inv_first_fail", first_fail, 0);
      check("inv_pass", pass, 0);
      sweep(3, -1, -1, cyc);
      check("glitch_err", err_count, 0);
      check("glitch_pass", pass, 1);
      sweep(0, -1, 'h40 * PER + 2, cyc);
      check("rst_stim", stim, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      sweep(0, -1, -1, cyc);
      check("post_rst_latency", cyc, 640);
      check("post_rst_pass", pass, 1);
      check("post_rst_stim", stim, 'h7f);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
